// File: rtl/sm_div_if.sv
// rtl/sm_div_if.sv - start/busy/done handshake and operand/result bundle for sm_div
//
// Ports (signals):
//   start      request, sampled by the divider only while idle
//   N, D       sign-magnitude dividend (NW bits) and divisor (DW bits)
//   busy, done operation in progress / single-cycle completion pulse
//   Q, R       sign-magnitude quotient (NW bits) and remainder (DW bits)
//   SF, ZF     quotient sign / quotient magnitude zero
//   DZF        divide-by-zero
// Modports: master drives the request side, slave is the divider.

interface sm_div_if #(
  parameter int NW = 5,
  parameter int DW = 3
);
  logic          start;
  logic [NW-1:0] N;
  logic [DW-1:0] D;
  logic          busy;
  logic          done;
  logic [NW-1:0] Q;
  logic [DW-1:0] R;
  logic          SF;
  logic          ZF;
  logic          DZF;

  modport master (
    output start, N, D,
    input  busy, done, Q, R, SF, ZF, DZF
  );

  modport slave (
    input  start, N, D,
    output busy, done, Q, R, SF, ZF, DZF
  );
endinterface

// File: rtl/sm_div.sv
// rtl/sm_div.sv - sequential sign-magnitude restoring divider, one quotient bit per clock
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts any operation in progress
//   bus  sm_div_if slave: start/N/D in, busy/done/Q/R/SF/ZF/DZF out
//
// Flow: IDLE latches operands on start, CALC runs NW-1 shift-subtract steps,
// FIN registers the signed results and raises done for one cycle. A zero
// divisor magnitude (+0 or -0) skips CALC entirely.

module sm_div #(
  parameter int NW = 5,
  parameter int DW = 3
) (
  input logic     clk,
  input logic     rst,
  sm_div_if.slave bus
);

  localparam int CW = $clog2(NW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NW-2:0] dvd;   // dividend magnitude, consumed MSB first
  logic [NW-2:0] quo;   // quotient magnitude, built LSB first
  logic [DW-2:0] dmag;  // divisor magnitude
  logic [DW-1:0] prem;  // partial remainder, one bit wider than the divisor
  logic [CW-1:0] cnt;   // iterations left
  logic          qsign;
  logic          rsign;
  logic          dz;

  logic [DW-1:0] shifted;
  logic [DW-1:0] diff;
  logic          ge;
  logic          accept;
  logic          q_nz;
  logic          r_nz;

  logic          done_q;
  logic [NW-1:0] q_out;
  logic [DW-1:0] r_out;
  logic          sf_out;
  logic          zf_out;
  logic          dzf_out;
  logic          busy_c;

  // The done cycle is spent in IDLE; masking start there keeps a request
  // coinciding with done from being taken.
  assign accept  = (state == IDLE) && bus.start && !done_q;

  // prem < dmag always holds between steps, so its top bit is zero and the
  // shifted value fits DW bits.
  assign shifted = {prem[DW-2:0], dvd[NW-2]};
  assign ge      = (shifted >= {1'b0, dmag});
  assign diff    = shifted - {1'b0, dmag};
  assign q_nz    = |quo;
  assign r_nz    = |prem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (bus.D[DW-2:0] == '0) ? FIN : CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(1)) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_c = 1'b0;
    case (state)
      CALC:    busy_c = 1'b1;
      FIN:     busy_c = 1'b1;
      default: busy_c = 1'b0;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd     <= '0;
      quo     <= '0;
      dmag    <= '0;
      prem    <= '0;
      cnt     <= '0;
      qsign   <= 1'b0;
      rsign   <= 1'b0;
      dz      <= 1'b0;
      done_q  <= 1'b0;
      q_out   <= '0;
      r_out   <= '0;
      sf_out  <= 1'b0;
      zf_out  <= 1'b0;
      dzf_out <= 1'b0;
    end else begin
      done_q <= (state == FIN);
      case (state)
        IDLE: begin
          if (accept) begin
            dvd   <= bus.N[NW-2:0];
            dmag  <= bus.D[DW-2:0];
            qsign <= bus.N[NW-1] ^ bus.D[DW-1];
            rsign <= bus.N[NW-1];
            prem  <= '0;
            quo   <= '0;
            cnt   <= CW'(NW - 1);
            dz    <= (bus.D[DW-2:0] == '0);
          end
        end
        CALC: begin
          dvd  <= {dvd[NW-3:0], 1'b0};
          prem <= ge ? diff : shifted;
          quo  <= {quo[NW-3:0], ge};
          cnt  <= cnt - CW'(1);
        end
        FIN: begin
          if (dz) begin
            q_out   <= '0;
            r_out   <= '0;
            sf_out  <= 1'b0;
            zf_out  <= 1'b1;
            dzf_out <= 1'b1;
          end else begin
            // Signs are masked by nonzero magnitude so -0 never escapes.
            q_out   <= {qsign & q_nz, quo};
            r_out   <= {rsign & r_nz, prem[DW-2:0]};
            sf_out  <= qsign & q_nz;
            zf_out  <= ~q_nz;
            dzf_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.Q    = q_out;
  assign bus.R    = r_out;
  assign bus.SF   = sf_out;
  assign bus.ZF   = zf_out;
  assign bus.DZF  = dzf_out;

endmodule

// File: tb/tb_sm_div.sv
// tb/tb_sm_div.sv - scoreboard bench for sm_div

module tb_sm_div;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sm_div_if #(.NW(5), .DW(3)) bus ();

  sm_div #(.NW(5), .DW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0] q;
    logic [2:0] r;
    logic       sf;
    logic       zf;
    logic       dzf;
    logic [3:0] lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0b exp=%0b @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard,
  // including how many cycles busy was high before it.
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done act=1 exp=0 @%0t", $time);
          end else begin
            e = sbq.pop_front();
            chk("Q", int'(bus.Q), int'(e.q));
            chk("R", int'(bus.R), int'(e.r));
            chk("SF", int'(bus.SF), int'(e.sf));
            chk("ZF", int'(bus.ZF), int'(e.zf));
            chk("DZF", int'(bus.DZF), int'(e.dzf));
            chk("busy_cycles", busy_cnt, int'(e.lat));
            chk("busy_with_done", int'(bus.busy), 0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s act=no_done exp=done", nm);
    end
  endtask

  task automatic run(input logic [4:0] n, input logic [2:0] d,
                     input logic [4:0] eq, input logic [2:0] er,
                     input logic esf, input logic ezf, input logic edzf,
                     input logic [3:0] lat);
    sbq.push_back('{q: eq, r: er, sf: esf, zf: ezf, dzf: edzf, lat: lat});
    @(negedge clk);
    bus.start = 1'b1;
    bus.N     = n;
    bus.D     = d;
    @(negedge clk);
    bus.start = 1'b0;
    bus.N     = ~n;
    bus.D     = 3'b001;
    wait_done("run");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] amag;
    logic [1:0] bmag;
    logic [3:0] pm;
    logic       ps;
    logic [4:0] eq;
    logic [2:0] bb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.N     = '0;
    bus.D     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_Q", int'(bus.Q), 0);
    chk("rst_R", int'(bus.R), 0);
    chk("rst_flags", int'({bus.SF, bus.ZF, bus.DZF}), 0);
    rst = 1'b0;

    run(5'b01001, 3'b011, 5'b00011, 3'b000, 0, 0, 0, 5);
    run(5'b10111, 3'b010, 5'b10011, 3'b101, 1, 0, 0, 5);
    run(5'b00101, 3'b000, 5'b00000, 3'b000, 0, 1, 1, 1);
    run(5'b00101, 3'b100, 5'b00000, 3'b000, 0, 1, 1, 1);
    run(5'b01001, 3'b011, 5'b00011, 3'b000, 0, 0, 0, 5);
    run(5'b00010, 3'b111, 5'b00000, 3'b010, 0, 1, 0, 5);
    run(5'b10000, 3'b011, 5'b00000, 3'b000, 0, 1, 0, 5);
    run(5'b10111, 3'b010, 5'b10011, 3'b101, 1, 0, 0, 5);

    // Second start two cycles into a divide must be ignored; outputs hold.
    sbq.push_back('{q: 5'b00011, r: 3'b000, sf: 0, zf: 0, dzf: 0, lat: 4'd5});
    @(negedge clk);
    bus.start = 1'b1;
    bus.N     = 5'b01001;
    bus.D     = 3'b011;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.N     = 5'b01111;
    bus.D     = 3'b001;
    chk("hold_Q", int'(bus.Q), 5'b10011);
    chk("hold_R", int'(bus.R), 3'b101);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore");
    repeat (8) @(negedge clk);

    // Reset mid-operation: outputs clear and no done follows.
    @(negedge clk);
    bus.start = 1'b1;
    bus.N     = 5'b01001;
    bus.D     = 3'b011;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_Q", int'(bus.Q), 0);
    chk("abort_R", int'(bus.R), 0);
    chk("abort_flags", int'({bus.SF, bus.ZF, bus.DZF}), 0);
    repeat (8) @(negedge clk);

    // Round trip through the sign-magnitude product format.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        bb   = 3'(b);
        bmag = bb[1:0];
        if (bmag != 2'b00) begin
          eq   = 5'(a);
          amag = eq[1:0];
          pm   = 4'(amag * bmag);
          ps   = (eq[2] ^ bb[2]) & (pm != 4'd0);
          $display("div N=%b D=%b A=%b", {ps, pm}, bb, eq[2:0]);
          run({ps, pm}, bb, {eq[2] & (amag != 2'b00), 2'b00, amag}, 3'b000,
              eq[2] & (amag != 2'b00), amag == 2'b00, 0, 5);
        end
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
